// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and the blocks it talks to.
// Holds the FSM state encoding, UART register map and default bus widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] ADDR_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATS = 32'h0000_0004;
  localparam logic [31:0] ADDR_TX    = 32'h0000_0008;
  localparam logic [31:0] ADDR_RX    = 32'h0000_000C;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 256;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter: clears on entry to ACCESS, counts stalled cycles.
// expired_o fires combinationally in the stalled cycle that would reach TIMEOUT.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This stalled cycle is the TIMEOUT-th one; PREADY in the same cycle still wins upstream.
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: command in, SETUP/ACCESS on the bus, one-cycle response pulse.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_en;

  assign tmo_clear = (state_q == SETUP);
  assign tmo_en    = (state_q == ACCESS) && !PREADY;

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_en),
    .expired_o (timeout_hit)
  );
`else
  // TIMEOUT only has meaning when the counter is built; ACCESS waits forever here.
  assign timeout_hit = 1'b0 & (TIMEOUT < 1);
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: wait-state completer model plus a response scoreboard.
// Timeout cases are exercised only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completer model: PREADY rises in ACCESS cycle waits_c+1 unless stuck.
  int          waits_c = 0;
  bit          stuck_c = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_write = 1'b0;

  always @(negedge PCLK) begin
    if (PSEL) begin
      chk("paddr_stable", PADDR, exp_addr);
      chk("pwrite_stable", PWRITE, exp_write);
      if (exp_write) chk("pwdata_stable", PWDATA, exp_wdata);
    end
    if (PSEL && PENABLE) acc_cnt++;
    else acc_cnt = 0;
    PREADY = !stuck_c && (acc_cnt == waits_c + 1);
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  always @(negedge PCLK) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int w, input bit stk,
                      input bit perr, input logic [31:0] prd, input bit tmo_exp,
                      input int exp_lat, input bit keep);
    int n;
    waits_c   = w;
    stuck_c   = stk;
    PSLVERR   = perr;
    PRDATA    = prd;
    exp_addr  = addr;
    exp_wdata = wdata;
    exp_write = wr;
    sb_q.push_back('{rdata: (wr || tmo_exp) ? 32'h0 : prd, err: perr || tmo_exp});
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk({tag, "_accept"}, cmd_ready, 1'b1);
    @(posedge PCLK);
    @(negedge PCLK);
    if (!keep) cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    xfer("wr_ctrl", 1'b1, ADDR_CTRL, 32'h5, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3, 1'b0);
    @(negedge PCLK);
    chk("wr_pulse_end", rsp_valid, 1'b0);
    chk("wr_psel_idle", PSEL, 1'b0);
    chk("wr_pwdata_hold", PWDATA, 32'h5);

    xfer("rd_stats", 1'b0, ADDR_STATS, 32'h0, 3, 1'b0, 1'b0, 32'h12, 1'b0, 6, 1'b0);
    @(negedge PCLK);
    chk("rd_rdata_hold", rsp_rdata, 32'h12);
    chk("rd_paddr_hold", PADDR, ADDR_STATS);
    chk("rd_penable_idle", PENABLE, 1'b0);

    xfer("b2b_wr", 1'b1, ADDR_TX, 32'hA5, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3, 1'b1);
    chk("b2b_psel_gap", PSEL, 1'b0);
    xfer("b2b_rd", 1'b0, ADDR_RX, 32'h0, 0, 1'b0, 1'b0, 32'h5A, 1'b0, 3, 1'b0);

    xfer("slverr", 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b1, 32'hDEAD_0010, 1'b0, 3, 1'b0);
    @(negedge PCLK);
    chk("slverr_err_hold", rsp_err, 1'b1);
    PSLVERR = 1'b0;

    // Abort a stalled read with reset partway through ACCESS.
    stuck_c   = 1'b1;
    exp_addr  = ADDR_STATS;
    exp_write = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = ADDR_STATS;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("abort_in_access", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("abort_psel", PSEL, 1'b0);
    chk("abort_penable", PENABLE, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    stuck_c = 1'b0;
    @(negedge PCLK);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_no_rsp", sb_q.size(), 0);
    xfer("post_rst", 1'b1, ADDR_RX, 32'h3C, 1, 1'b0, 1'b0, 32'h0, 1'b0, 4, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer("tmo_stuck", 1'b0, ADDR_RX, 32'h0, 0, 1'b1, 1'b0, 32'h99, 1'b1, 6, 1'b0);
    stuck_c = 1'b0;
    xfer("tmo_race", 1'b0, ADDR_RX, 32'h0, 3, 1'b0, 1'b0, 32'h77, 1'b0, 6, 1'b0);
`endif

    repeat (3) @(negedge PCLK);
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that turns a simple single-outstanding command/response interface into APB SETUP/ACCESS transfers.
- Drives any APB completer in the design, including the UART register block (CTRL 0x00, STATS 0x04, TX 0x08, RX 0x0C).
- Intended users are a test sequencer or a small CPU-side bridge.
- Exactly one transfer is in flight at a time; wait states are honoured via PREADY.

Parameters:
- ADDR_W, 32, width of cmd_addr/PADDR.
- DATA_W, 32, width of data buses.
- TIMEOUT, 256, ACCESS-phase cycle limit; used only when APB_MASTER_TIMEOUT_EN is defined; must be ≥1.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error; tie 0 if the completer has none.

Behaviour:
- Reset (PRESETn low, async): state IDLE; all outputs 0 except cmd_ready = 1.
  - Reset mid-transfer drops PSEL/PENABLE immediately.
  - No rsp_valid is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr/wdata/write into PADDR/PWDATA/PWRITE and go to SETUP.
  - Next cycle PSEL = 1, PENABLE = 0.
- SETUP: lasts exactly one cycle; then ACCESS with PSEL = 1, PENABLE = 1.
- ACCESS:
  - Hold PADDR/PWDATA/PWRITE/PSEL/PENABLE stable while PREADY = 0 (unbounded wait unless timeout is compiled in).
  - On the PREADY = 1 edge: next cycle PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_rdata = PRDATA on reads, 0 on writes; rsp_err = PSLVERR. State returns to IDLE.
- cmd_ready is 0 in SETUP and ACCESS. cmd_valid there is ignored; the requester holds it until accepted.
- Minimum transfer: accept edge to rsp_valid is 3 cycles (no wait states). Back-to-back throughput is one transfer per 3 cycles.
  - A command presented in the rsp_valid cycle (IDLE) is accepted that cycle.
- Between transfers PADDR/PWDATA/PWRITE hold their last values; PSEL = PENABLE = 0.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata/rsp_err hold until the next response.
- PREADY/PRDATA/PSLVERR are sampled only in ACCESS and ignored in IDLE/SETUP.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When it reaches TIMEOUT: terminate the transfer (PSEL = PENABLE = 0 next cycle), rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, state IDLE.
  - PREADY in the same cycle as the limit wins: normal completion.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: no counter logic; ACCESS waits for PREADY indefinitely.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE/SETUP/ACCESS).
  - UART register address constants (ADDR_CTRL 0x00, ADDR_STATS 0x04, ADDR_TX 0x08, ADDR_RX 0x0C).
  - Default-width localparams.
- Sub-module apb_timeout_cnt (clear, enable, expired), instantiated only under APB_MASTER_TIMEOUT_EN.
- FSM and datapath stay in apb_master.

Test Plan:
- Write 0x0000_0005 to 0x00, completer with PREADY = 1 → SETUP then ACCESS each 1 cycle, PWDATA = 5, rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
- Read 0x04 with 3 wait states, PRDATA = 0x0000_0012 → PSEL/PENABLE/PADDR stable for 4 ACCESS cycles, rsp_rdata = 0x12, accept to rsp_valid = 6 cycles.
- Back-to-back: cmd_valid held high, write 0x08 = 0xA5 then read 0x0C → second accept in the rsp_valid cycle of the first, no PSEL gap beyond one IDLE cycle.
- PSLVERR = 1 with PREADY on a read of 0x10 → rsp_err = 1, rsp_rdata = PRDATA, state IDLE.
- PRESETn low during ACCESS wait → PSEL/PENABLE/rsp_valid = 0 immediately, cmd_ready = 1 after release, the next command completes normally.
- APB_MASTER_TIMEOUT_EN, TIMEOUT = 4, PREADY stuck 0 → rsp_valid with rsp_err = 1 after 4 ACCESS cycles. Repeat with PREADY rising in cycle 4 → rsp_err = 0.
